// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared types for the PWM sample scheduler.
// Sequencer state encoding and underrun counter width.
package pwm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    UNDERRUN
  } state_t;

  localparam int UR_CNT_W = 16;

endpackage

// File: rtl/pwm_sample_scheduler_fifo.sv
// sample_fifo: synchronous FIFO with flush and occupancy output.
// Ports: clk, rst, flush, push/wr_data, pop/rd_data, level.
module sample_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler: paces a valid/ready sample stream into a PWM,
// one sample per 2^COUNTER_WIDTH-clock frame, zero when starved.
// Ports: clk, rst, enable, s_data/s_valid/s_ready, pwm_data,
// frame_start, level, running, underrun(_clr), underrun_count.
// Option: PWM_SCHED_UNDERRUN_CNT_EN enables the underrun counter.
module pwm_sample_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int FIFO_DEPTH    = 8,
  parameter int PREFILL       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DATA_WIDTH-1:0]       pwm_data,
  output logic                        frame_start,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        running,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [UR_CNT_W-1:0]         underrun_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);

  state_t                   state_q;
  state_t                   state_d;
  logic [COUNTER_WIDTH-1:0] frame_cnt;
  logic [DATA_WIDTH-1:0]    head;
  logic                     upd;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic                     load;
  logic                     zero;
  logic                     ur_set;

  // Last clock of the frame: the value written here is what the
  // PWM latches while frame_cnt is 0.
  assign upd         = &frame_cnt;
  assign frame_start = (frame_cnt == '0);
  assign running     = (state_q == RUN);
  assign s_ready     = (state_q != IDLE) && (level < FULL_LVL);
  assign push        = s_valid && s_ready;
  assign flush       = !enable || (state_q == IDLE);

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (head),
    .level   (level)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    zero    = 1'b0;
    ur_set  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      zero    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL, UNDERRUN: begin
          if (upd && level >= PRE_LVL) begin
            state_d = RUN;
            pop     = 1'b1;
            load    = 1'b1;
          end
        end
        RUN: begin
          if (upd) begin
            if (level != '0) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_d = UNDERRUN;
              zero    = 1'b1;
              ur_set  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_cnt <= '0;
      pwm_data  <= '0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_cnt <= frame_cnt + COUNTER_WIDTH'(1);
      if (zero)
        pwm_data <= '0;
      else if (load)
        pwm_data <= head;
      if (ur_set)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

`ifdef PWM_SCHED_UNDERRUN_CNT_EN
  logic [UR_CNT_W-1:0] ur_cnt;

  // Saturating; a new underrun beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)
      ur_cnt <= '0;
    else if (ur_set) begin
      if (ur_cnt != '1)
        ur_cnt <= ur_cnt + UR_CNT_W'(1);
    end else if (underrun_clr)
      ur_cnt <= '0;
  end

  assign underrun_count = ur_cnt;
`else
  assign underrun_count = '0;
`endif

endmodule
